// File: rtl/gr_row_sched.sv
// Row scheduler for the Givens-rotation chain: buffers one row from a valid/ready stream,
// replays it gap-free with first/last framing, and tracks rows returning from the chain tail.
module gr_row_sched #(
  parameter int unsigned DATA_W    = 13,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  parameter int unsigned DI_W      = 12,
  parameter int unsigned GAP_CYC   = 2,
  parameter int unsigned DRAIN_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DI_W-1:0]   cfg_di,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] gr_data,
  output logic              gr_first,
  output logic              gr_last,
  output logic [DI_W-1:0]   gr_di,
  input  logic              gr_last_ret,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = $clog2(ROWS + 1);
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [IW-1:0] ColLast   = IW'(COLS - 1);
  localparam logic [RW-1:0] RowsN     = RW'(ROWS);
  localparam logic [GW-1:0] GapLast   = GW'(GAP_CYC - 1);
  localparam logic [DW-1:0] DrainLast = DW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {StIdle, StFill, StIssue, StGap, StDrain} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     col_q, col_d, col_nxt;
  logic [RW-1:0]     row_q, row_d, ret_q, ret_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [DI_W-1:0]   di_q, di_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              first_q, first_d, last_q, last_d;
  logic              rdy_q, rdy_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] row_buf_q [COLS];
  logic [DATA_W-1:0] row_buf_d [COLS];

  assign col_nxt = col_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    ret_d     = ret_q;
    gap_d     = gap_q;
    drain_d   = drain_q;
    di_d      = di_q;
    row_buf_d = row_buf_q;
    data_d    = '0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    rdy_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (state_q != StIdle && gr_last_ret && ret_q != RowsN) begin
      ret_d = ret_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          di_d    = cfg_di;
          col_d   = '0;
          row_d   = '0;
          ret_d   = '0;
          state_d = StFill;
          rdy_d   = 1'b1;
        end
      end
      StFill: begin
        rdy_d = 1'b1;
        if (in_valid && rdy_q) begin
          row_buf_d[col_q] = in_data;
          if (col_q == ColLast) begin
            // Element 0 leaves on the same edge as the final write, so issue is gap-free.
            col_d   = '0;
            rdy_d   = 1'b0;
            state_d = StIssue;
            data_d  = row_buf_d[0];
            first_d = 1'b1;
            last_d  = (COLS == 1);
          end else begin
            col_d = col_nxt;
          end
        end
      end
      StIssue: begin
        if (col_q == ColLast) begin
          col_d   = '0;
          row_d   = row_q + 1'b1;
          gap_d   = '0;
          state_d = StGap;
        end else begin
          col_d  = col_nxt;
          data_d = row_buf_q[col_nxt];
          last_d = (col_nxt == ColLast);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d = '0;
          if (row_q == RowsN) begin
            drain_d = '0;
            state_d = StDrain;
          end else begin
            rdy_d   = 1'b1;
            state_d = StFill;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDrain: begin
        if (ret_q == RowsN) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (drain_q == DrainLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      col_d   = '0;
      row_d   = '0;
      ret_d   = '0;
      gap_d   = '0;
      drain_d = '0;
      di_d    = di_q;
      data_d  = '0;
      first_d = 1'b0;
      last_d  = 1'b0;
      rdy_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    // Busy stays up through the cycle that carries the done/err pulse.
    busy_d = (state_d != StIdle) || done_d || err_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      ret_q   <= '0;
      gap_q   <= '0;
      drain_q <= '0;
      di_q    <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ret_q   <= ret_d;
      gap_q   <= gap_d;
      drain_q <= drain_d;
      di_q    <= di_d;
      data_q  <= data_d;
      first_q <= first_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    row_buf_q <= row_buf_d;
  end

  assign in_ready = rdy_q;
  assign gr_data  = data_q;
  assign gr_first = first_q;
  assign gr_last  = last_q;
  assign gr_di    = di_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_gr_row_sched.sv
// Scoreboard bench for gr_row_sched: accepted samples predict the issued rows; a monitor
// compares every cycle of chain output, and end-of-matrix pulses are checked for timing.
module tb_gr_row_sched;
  localparam int DATA_W = 13, ROWS = 4, COLS = 4, DI_W = 12, GAP_CYC = 2, DRAIN_MAX = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [DI_W-1:0]   cfg_di = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0, in_ready;
  logic [DATA_W-1:0] gr_data;
  logic              gr_first, gr_last;
  logic [DI_W-1:0]   gr_di;
  logic              gr_last_ret = 1'b0;
  logic              busy, done, err;

  gr_row_sched #(
    .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .DI_W(DI_W), .GAP_CYC(GAP_CYC),
    .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_di(cfg_di),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .gr_data(gr_data),
    .gr_first(gr_first), .gr_last(gr_last), .gr_di(gr_di), .gr_last_ret(gr_last_ret),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
    logic              first;
    logic              last;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] stim_q[$];
  logic [DI_W-1:0]   exp_di = '0;
  int vectors = 0, miscompares = 0;
  int last_hs_edge = 0, last_elem_cyc = 0;
  bit ret_en = 1'b1;
  logic [2:0] ret_sr = '0;
  int ret_count = 0, ret_last_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: an expected element is due on its cycle; any other cycle must be quiet.
  exp_t e;
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("issue_missed", 64'(cyc), 64'(exp_q[0].cyc));
      e = exp_q.pop_front();
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("gr_data", gr_data, e.data);
      chk("gr_first", gr_first, e.first);
      chk("gr_last", gr_last, e.last);
      chk("gr_di", gr_di, exp_di);
    end else begin
      chk("quiet_data", gr_data, 0);
      chk("quiet_frame", {gr_first, gr_last}, 0);
    end
  end

  // Chain model: last_out returns three cycles after gr_last.
  always @(negedge clk) begin
    gr_last_ret = ret_en & ret_sr[2];
    if (gr_last_ret) begin
      ret_count++;
      if (ret_count == ROWS) ret_last_cyc = cyc;
    end
    ret_sr = {ret_sr[1:0], gr_last};
  end

  task automatic do_start(input logic [DI_W-1:0] di);
    @(negedge clk);
    start  = 1'b1;
    cfg_di = di;
    exp_di = di;
    ret_count = 0;
    @(negedge clk);
    start  = 1'b0;
    cfg_di = $urandom;
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", in_ready, 1);
  endtask

  // mode 0: valid held high, 1: valid toggles, 2: random valid.
  task automatic send(input int n, input int mode, input bit chk_gap);
    logic [DATA_W-1:0] row [COLS];
    logic [DATA_W-1:0] d;
    exp_t t;
    int j, waited, prev_last, hs_e;
    bit acc;
    j = 0;
    prev_last = -1;
    in_valid = 1'b0;
    for (int s = 0; s < n; s++) begin
      d = stim_q.pop_front();
      acc = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge clk);
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = ~in_valid;
          default: in_valid = ($urandom_range(0, 3) != 0);
        endcase
        in_data = d;
        if (in_valid && in_ready) acc = 1'b1;
        else if (++waited > 300) begin
          chk("fill_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
      hs_e = cyc + 1;
      row[j] = d;
      if (chk_gap && j == 0 && prev_last >= 0)
        chk("row_spacing", 64'(hs_e - prev_last), 64'(COLS + GAP_CYC + 1));
      if (j == COLS - 1) begin
        for (int k = 0; k < COLS; k++) begin
          t.cyc = hs_e + k;
          t.data = row[k];
          t.first = (k == 0);
          t.last = (k == COLS - 1);
          exp_q.push_back(t);
        end
        last_elem_cyc = hs_e + COLS - 1;
        last_hs_edge = hs_e;
        prev_last = hs_e;
        j = 0;
      end else begin
        j++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input bit exp_done);
    int n, expc, a, b;
    bit bad;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || err) && n < 400);
    if (!(done || err)) begin
      chk("end_timeout", 0, 1);
      return;
    end
    chk("done_flag", done, exp_done);
    chk("err_flag", err, !exp_done);
    if (exp_done) begin
      chk("ret_count", 64'(ret_count), 64'(ROWS));
      a = last_elem_cyc + GAP_CYC + 1;
      b = ret_last_cyc + 1;
      expc = ((a > b) ? a : b) + 1;
    end else begin
      expc = last_elem_cyc + GAP_CYC + DRAIN_MAX + 1;
    end
    chk("end_cycle", 64'(cyc), 64'(expc));
    chk("busy_with_pulse", busy, 1);
    @(negedge clk);
    chk("busy_after_end", busy, 0);
    bad = done | err;
    repeat (3) begin
      @(negedge clk);
      bad |= done | err;
    end
    chk("single_pulse", bad, 0);
    chk("queue_drained", 64'(exp_q.size()), 0);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) stim_q.push_back(DATA_W'(i));
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(DATA_W'($urandom));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DI_W-1:0] di1;
    int hs, bad_i;
    bit bad;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, err}, 0);
    chk("rst_di", gr_di, 0);

    // Held valid, sequential samples, loopback returns.
    do_start(12'h123);
    push_range(1, 16);
    send(16, 0, 1'b1);
    wait_end(1'b1);

    // Toggling valid still issues gap-free rows.
    do_start(12'h3C1);
    push_range(17, 32);
    send(16, 1, 1'b0);
    wait_end(1'b1);

    // Extreme signed values and a held direction vector.
    do_start(12'hA5C);
    repeat (4) begin
      stim_q.push_back(13'h1000);
      stim_q.push_back(13'h0FFF);
      stim_q.push_back(13'h1FFF);
      stim_q.push_back(13'h0000);
    end
    send(16, 0, 1'b1);
    wait_end(1'b1);
    chk("di_held_after_done", gr_di, 12'hA5C);

    // No returns: drain timeout, then a fresh start still works.
    ret_en = 1'b0;
    do_start(12'h7E7);
    push_random(16);
    send(16, 0, 1'b0);
    wait_end(1'b0);
    ret_en = 1'b1;
    repeat (4) @(negedge clk);
    do_start(12'h001);
    push_random(16);
    send(16, 0, 1'b0);
    wait_end(1'b1);

    // Abort during the second issue cycle of row 2.
    do_start(12'h55A);
    push_random(8);
    send(8, 0, 1'b0);
    hs = last_hs_edge;
    @(negedge clk);
    chk("abort_setup_cycle", 64'(cyc), 64'(hs + 1));
    abort = 1'b1;
    while (exp_q.size() > 0 && exp_q[$].cyc >= hs + 2) exp_q.pop_back();
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_first", gr_first, 0);
    chk("abort_di_kept", gr_di, 12'h55A);
    bad = 1'b0;
    bad_i = 0;
    repeat (20) begin
      @(negedge clk);
      bad |= done | err | busy;
    end
    chk("abort_quiet", bad, bad_i[0]);
    do_start(12'h2B4);
    push_random(16);
    send(16, 2, 1'b0);
    wait_end(1'b1);

    // Start while busy is ignored.
    di1 = 12'h9D3;
    do_start(di1);
    push_random(16);
    send(4, 0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    cfg_di = ~di1;
    @(negedge clk);
    start = 1'b0;
    send(12, 0, 1'b1);
    wait_end(1'b1);
    chk("di_ignores_busy_start", gr_di, di1);

    // Reset mid-fill clears everything including the direction vector.
    do_start(12'hFFF);
    push_random(2);
    send(2, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_di = '0;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", {gr_data, gr_first, gr_last, done, err}, 0);
    chk("mid_rst_di", gr_di, 0);
    repeat (4) @(negedge clk);

    // Randomized matrices.
    repeat (4) begin
      do_start(DI_W'($urandom));
      push_random(16);
      send(16, 2, 1'b0);
      wait_end(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
